cc_host_sequencer: RTL and testbench

Host-side driver for the compute core's external interface. It accepts one job descriptor at a time, streams operand words into core BRAM over the external write port, issues the packed instruction, and waits for `done_ins_computation` (with a watchdog). It then streams a result window back out of BRAM and reports status. It sits between the host FIFO/DMA logic and the compute core, and is the only agent driving `command_in` and `address_ext`.

---
 rtl/cc_host_sequencer_if.sv | 54 +++++
 rtl/cc_host_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_cc_host_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_host_sequencer_if.sv
// Signal bundle between the host FIFO/DMA side, the compute core and cc_host_sequencer.
// master is the sequencer; slave is everything around it (host streams and core port).
interface cc_host_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_ins;
    logic [9:0]  req_op1;
    logic [9:0]  req_op2;
    logic [9:0]  req_op3;
    logic [9:0]  req_ld_base;
    logic [9:0]  req_ul_base;
    logic [10:0] req_ld_len;
    logic [10:0] req_ul_len;

    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_data;

    logic        ul_valid;
    logic        ul_ready;
    logic [63:0] ul_data;

    logic [9:0]  address_ext;
    logic [63:0] dina_ext;
    logic        wea_ext;
    logic [34:0] command_in;
    logic        command_we0;
    logic        command_we1;
    logic [63:0] doutb_ext;
    logic        done_ins_computation;

    logic        resp_valid;
    logic        resp_timeout;
    logic [31:0] resp_cycles;
    logic        busy;

    modport master (
        input  req_valid, req_ins, req_op1, req_op2, req_op3,
               req_ld_base, req_ul_base, req_ld_len, req_ul_len,
               ld_valid, ld_data, ul_ready, doutb_ext, done_ins_computation,
        output req_ready, ld_ready, ul_valid, ul_data,
               address_ext, dina_ext, wea_ext, command_in, command_we0, command_we1,
               resp_valid, resp_timeout, resp_cycles, busy
    );

    modport slave (
        output req_valid, req_ins, req_op1, req_op2, req_op3,
               req_ld_base, req_ul_base, req_ld_len, req_ul_len,
               ld_valid, ld_data, ul_ready, doutb_ext, done_ins_computation,
        input  req_ready, ld_ready, ul_valid, ul_data,
               address_ext, dina_ext, wea_ext, command_in, command_we0, command_we1,
               resp_valid, resp_timeout, resp_cycles, busy
    );
endinterface

// File: rtl/cc_host_sequencer.sv
// Host-side job sequencer for the compute core: NOP, load operands, execute with
// watchdog, NOP, unload a result window, then report status.
module cc_host_sequencer #(
    parameter int unsigned RD_LAT  = 1,
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input logic                 clk,
    input logic                 rst,
    cc_host_sequencer_if.master bus
);
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_NOP0       = 4'd1;
    localparam logic [3:0] S_LOAD       = 4'd2;
    localparam logic [3:0] S_LFLUSH     = 4'd3;
    localparam logic [3:0] S_EXEC_ISSUE = 4'd4;
    localparam logic [3:0] S_EXEC_WAIT  = 4'd5;
    localparam logic [3:0] S_EXEC_NOP   = 4'd6;
    localparam logic [3:0] S_UL_ADDR    = 4'd7;
    localparam logic [3:0] S_UL_WAIT    = 4'd8;
    localparam logic [3:0] S_UL_OUT     = 4'd9;
    localparam logic [3:0] S_RESP       = 4'd10;

    localparam int unsigned   LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        return (len > 11'd1024) ? 11'd1024 : len;
    endfunction

    function automatic logic [3:0] after_exec(input logic [10:0] ul_len);
        return (ul_len != 11'd0) ? S_UL_ADDR : S_RESP;
    endfunction

    function automatic logic [3:0] after_load(input logic [4:0] ins, input logic [10:0] ul_len);
        return (ins != 5'd0) ? S_EXEC_ISSUE : after_exec(ul_len);
    endfunction

    logic [3:0]    state_q, state_d;
    logic [4:0]    ins_q, ins_d;
    logic [9:0]    op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic [9:0]    ld_base_q, ld_base_d, ul_base_q, ul_base_d;
    logic [10:0]   ld_len_q, ld_len_d, ul_len_q, ul_len_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [31:0]   cyc_q, cyc_d, cyc_inc;
    logic          tmo_q, tmo_d;
    logic [9:0]    addr_q, addr_d;
    logic [63:0]   dina_q, dina_d;
    logic          wea_q, wea_d;
    logic [34:0]   cmd_q, cmd_d;
    logic          cmd_we0_q, cmd_we0_d;
    logic          ul_valid_q, ul_valid_d;
    logic [63:0]   ul_data_q, ul_data_d;

    always_comb begin
        state_d    = state_q;
        ins_d      = ins_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        op3_d      = op3_q;
        ld_base_d  = ld_base_q;
        ul_base_d  = ul_base_q;
        ld_len_d   = ld_len_q;
        ul_len_d   = ul_len_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        cyc_d      = cyc_q;
        cyc_inc    = cyc_q + 32'd1;
        tmo_d      = tmo_q;
        addr_d     = addr_q;
        dina_d     = dina_q;
        wea_d      = 1'b0;
        ul_data_d  = ul_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    ins_d     = bus.req_ins;
                    op1_d     = bus.req_op1;
                    op2_d     = bus.req_op2;
                    op3_d     = bus.req_op3;
                    ld_base_d = bus.req_ld_base;
                    ul_base_d = bus.req_ul_base;
                    ld_len_d  = clamp_len(bus.req_ld_len);
                    ul_len_d  = clamp_len(bus.req_ul_len);
                    cnt_d     = 11'd0;
                    cyc_d     = 32'd0;
                    tmo_d     = 1'b0;
                    state_d   = S_NOP0;
                end
            end
            S_NOP0:       state_d = (ld_len_q != 11'd0) ? S_LOAD : after_load(ins_q, ul_len_q);
            S_LOAD: begin
                if (bus.ld_valid) begin
                    wea_d  = 1'b1;
                    addr_d = ld_base_q + cnt_q[9:0];
                    dina_d = bus.ld_data;
                    if (cnt_q == ld_len_q - 11'd1) begin
                        cnt_d   = 11'd0;
                        state_d = S_LFLUSH;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            S_LFLUSH:     state_d = after_load(ins_q, ul_len_q);
            S_EXEC_ISSUE: state_d = S_EXEC_WAIT;
            S_EXEC_WAIT: begin
                // done has priority over a watchdog expiry in the same cycle
                cyc_d = cyc_inc;
                if (bus.done_ins_computation) begin
                    state_d = S_EXEC_NOP;
                end else if ((TIMEOUT != 32'd0) && (cyc_inc == TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = S_EXEC_NOP;
                end
            end
            S_EXEC_NOP:   state_d = after_exec(ul_len_q);
            S_UL_ADDR: begin
                if (RD_LAT == 0) begin
                    ul_data_d = bus.doutb_ext;
                    state_d   = S_UL_OUT;
                end else begin
                    lat_d   = '0;
                    state_d = S_UL_WAIT;
                end
            end
            S_UL_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    ul_data_d = bus.doutb_ext;
                    state_d   = S_UL_OUT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_UL_OUT: begin
                if (bus.ul_ready) begin
                    if (cnt_q == ul_len_q - 11'd1) begin
                        cnt_d   = 11'd0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = cnt_q + 11'd1;
                        state_d = S_UL_ADDR;
                    end
                end
            end
            S_RESP:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        // Registered core-side outputs are decoded from the upcoming state
        if (state_d == S_UL_ADDR) begin
            addr_d = ul_base_q + cnt_d[9:0];
        end
        cmd_we0_d  = (state_d == S_NOP0) || (state_d == S_EXEC_ISSUE) || (state_d == S_EXEC_NOP);
        cmd_d      = (state_d == S_EXEC_ISSUE) ? {op3_q, op2_q, op1_q, ins_q} : 35'd0;
        ul_valid_d = (state_d == S_UL_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 11'd0;
            lat_q      <= '0;
            cyc_q      <= 32'd0;
            tmo_q      <= 1'b0;
            addr_q     <= 10'd0;
            dina_q     <= 64'd0;
            wea_q      <= 1'b0;
            cmd_q      <= 35'd0;
            cmd_we0_q  <= 1'b0;
            ul_valid_q <= 1'b0;
            ul_data_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            cyc_q      <= cyc_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            dina_q     <= dina_d;
            wea_q      <= wea_d;
            cmd_q      <= cmd_d;
            cmd_we0_q  <= cmd_we0_d;
            ul_valid_q <= ul_valid_d;
            ul_data_q  <= ul_data_d;
        end
    end

    // Descriptor fields are only meaningful once latched, so they carry no reset
    always_ff @(posedge clk) begin
        ins_q     <= ins_d;
        op1_q     <= op1_d;
        op2_q     <= op2_d;
        op3_q     <= op3_d;
        ld_base_q <= ld_base_d;
        ul_base_q <= ul_base_d;
        ld_len_q  <= ld_len_d;
        ul_len_q  <= ul_len_d;
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.ld_ready     = (state_q == S_LOAD);
    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_timeout = tmo_q;
    assign bus.resp_cycles  = cyc_q;
    assign bus.ul_valid     = ul_valid_q;
    assign bus.ul_data      = ul_data_q;
    assign bus.address_ext  = addr_q;
    assign bus.dina_ext     = dina_q;
    assign bus.wea_ext      = wea_q;
    assign bus.command_in   = cmd_q;
    assign bus.command_we0  = cmd_we0_q;
    assign bus.command_we1  = 1'b0;
endmodule

// File: tb/tb_cc_host_sequencer.sv
// Bench for cc_host_sequencer: core BRAM/done stub, stream drivers, and a job-level
// reference model predicting writes, commands, unloaded words and status.
module tb_cc_host_sequencer;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cc_host_sequencer_if bus();

    cc_host_sequencer #(.RD_LAT(1), .TIMEOUT(32'(TMO))) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Core stub: 1-cycle-latency BRAM behind the external port, done after a programmable delay
    logic [63:0] core_mem [1024];
    int          done_delay = 0;
    int          exec_cnt   = 0;
    logic        exec_armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) core_mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
            exec_armed <= 1'b0;
            exec_cnt   <= 0;
        end else begin
            if (bus.wea_ext) core_mem[bus.address_ext] <= bus.dina_ext;
            if (bus.command_we0 && bus.command_in[4:0] != 5'd0) begin
                exec_armed <= 1'b1;
                exec_cnt   <= 1;
            end else if (bus.command_we0) begin
                exec_armed <= 1'b0;
            end else if (exec_armed) begin
                exec_cnt <= exec_cnt + 1;
            end
        end
        bus.doutb_ext <= core_mem[bus.address_ext];
    end

    assign bus.done_ins_computation = exec_armed && (done_delay != 0) && (exec_cnt == done_delay);

    bit [63:0] ref_mem [1024];

    task automatic ref_init();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [9:0]  a;
        logic [63:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [34:0] cmd_q[$];
    logic [63:0] ul_q[$];
    int          resp_n = 0;
    logic        resp_to;
    logic [31:0] resp_cyc;

    // Monitor: records every core write, command write, unload handshake and response
    initial begin
        logic        holding;
        logic [63:0] held;
        holding = 1'b0;
        held    = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = 1'b0;
            end else begin
                if (bus.wea_ext) wr_q.push_back({bus.address_ext, bus.dina_ext});
                if (bus.command_we0) cmd_q.push_back(bus.command_in);
                if (bus.ul_valid && bus.ul_ready) ul_q.push_back(bus.ul_data);
                if (bus.resp_valid) begin
                    resp_n++;
                    resp_to  = bus.resp_timeout;
                    resp_cyc = bus.resp_cycles;
                end
                if (holding) begin
                    chk("ul_hold_valid", bus.ul_valid, 1);
                    chk("ul_hold_data", bus.ul_data, held);
                end
                holding = bus.ul_valid && !bus.ul_ready;
                held    = bus.ul_data;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ld_ready"}, bus.ld_ready, 0);
        chk({tag, "_ul_valid"}, bus.ul_valid, 0);
        chk({tag, "_ul_data"}, bus.ul_data, 0);
        chk({tag, "_address"}, bus.address_ext, 0);
        chk({tag, "_dina"}, bus.dina_ext, 0);
        chk({tag, "_wea"}, bus.wea_ext, 0);
        chk({tag, "_cmd"}, bus.command_in, 0);
        chk({tag, "_we0"}, bus.command_we0, 0);
        chk({tag, "_we1"}, bus.command_we1, 0);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_resp_timeout"}, bus.resp_timeout, 0);
        chk({tag, "_resp_cycles"}, bus.resp_cycles, 0);
    endtask

    task automatic drive_load(input logic [63:0] w[$], input int mode);
        int i = 0;
        int g = 0;
        while (i < w.size() && g < 10000) begin
            bus.ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : ($urandom_range(0, 2) != 0);
            bus.ld_data  = w[i];
            @(negedge clk);
            if (bus.ld_valid && bus.ld_ready) i++;
            @(posedge clk); #1;
            g++;
        end
        bus.ld_valid = 1'b0;
        chk("ld_beats_done", 64'(i), 64'(w.size()));
    endtask

    task automatic drive_unload(input int n, input int mode);
        int j = 0;
        int g = 0;
        int stall = 0;
        while (j < n && g < 20000) begin
            bus.ul_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : !(j == 1 && stall < 5);
            @(negedge clk);
            if (bus.ul_valid && bus.ul_ready) begin
                j++;
            end else if (mode == 2 && bus.ul_valid && j == 1) begin
                stall++;
                chk("busy_during_stall", bus.busy, 1);
            end
            @(posedge clk); #1;
            g++;
        end
        bus.ul_ready = 1'b0;
        chk("ul_words_done", 64'(j), 64'(n));
    endtask

    task automatic wait_resp();
        int g = 0;
        while (resp_n == 0 && g < 30000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic run_job(input string name, input int ins, input int o1, input int o2, input int o3,
                           input int lb, input int ub, input int ll, input int ul,
                           input int delay, input int ld_mode, input int ul_mode, input longint seed);
        int          nl, nu, g;
        logic        acc;
        logic [63:0] words[$];
        bit          exp_to;
        longint      exp_cyc, exp_cmd;

        nl = (ll > 1024) ? 1024 : ll;
        nu = (ul > 1024) ? 1024 : ul;
        for (int i = 0; i < nl; i++) words.push_back((seed != 0) ? 64'(seed + i) : {$urandom, $urandom});
        wr_q.delete();
        cmd_q.delete();
        ul_q.delete();
        resp_n     = 0;
        done_delay = delay;

        @(posedge clk); #1;
        bus.req_ins     = 5'(ins);
        bus.req_op1     = 10'(o1);
        bus.req_op2     = 10'(o2);
        bus.req_op3     = 10'(o3);
        bus.req_ld_base = 10'(lb);
        bus.req_ul_base = 10'(ub);
        bus.req_ld_len  = 11'(ll);
        bus.req_ul_len  = 11'(ul);
        bus.req_valid   = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk); #1;
            g++;
        end while (!acc && g < 100);
        chk({name, "_accept"}, acc, 1);
        // Descriptor noise while busy must not leak into the job
        bus.req_valid   = 1'b0;
        bus.req_ins     = 5'($urandom);
        bus.req_op1     = 10'($urandom);
        bus.req_ld_base = 10'($urandom);
        bus.req_ul_base = 10'($urandom);
        bus.req_ld_len  = 11'($urandom);
        bus.req_ul_len  = 11'($urandom);

        fork
            drive_load(words, ld_mode);
            drive_unload(nu, ul_mode);
            wait_resp();
        join
        repeat (2) @(posedge clk);
        #1;

        exp_to  = (ins != 0) && !(delay >= 1 && delay <= TMO);
        exp_cyc = (ins == 0) ? 0 : (exp_to ? TMO : delay);
        exp_cmd = ins + o1 * 32 + o2 * 32768 + longint'(o3) * 33554432;
        for (int i = 0; i < nl; i++) ref_mem[(lb + i) % 1024] = words[i];

        chk({name, "_resp_count"}, 64'(resp_n), 1);
        chk({name, "_resp_timeout"}, resp_to, 64'(exp_to));
        chk({name, "_resp_cycles"}, resp_cyc, 64'(exp_cyc));
        chk({name, "_idle"}, bus.req_ready, 1);
        chk({name, "_wr_count"}, 64'(wr_q.size()), 64'(nl));
        for (int i = 0; i < nl && i < wr_q.size(); i++) begin
            chk({name, "_wr_addr"}, wr_q[i].a, 64'((lb + i) % 1024));
            chk({name, "_wr_data"}, wr_q[i].d, words[i]);
        end
        chk({name, "_cmd_count"}, 64'(cmd_q.size()), (ins != 0) ? 64'd3 : 64'd1);
        if (cmd_q.size() > 0) chk({name, "_cmd_nop0"}, cmd_q[0], 0);
        if (ins != 0 && cmd_q.size() == 3) begin
            chk({name, "_cmd_exec"}, cmd_q[1], 64'(exp_cmd));
            chk({name, "_cmd_nop_after"}, cmd_q[2], 0);
        end
        chk({name, "_ul_count"}, 64'(ul_q.size()), 64'(nu));
        for (int j = 0; j < nu && j < ul_q.size(); j++) begin
            chk({name, "_ul_data"}, ul_q[j], ref_mem[(ub + j) % 1024]);
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_ins     = 5'd0;
        bus.req_op1     = 10'd0;
        bus.req_op2     = 10'd0;
        bus.req_op3     = 10'd0;
        bus.req_ld_base = 10'd0;
        bus.req_ul_base = 10'd0;
        bus.req_ld_len  = 11'd0;
        bus.req_ul_len  = 11'd0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = 64'd0;
        bus.ul_ready    = 1'b0;
        ref_init();

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Minimum latency: accept at 0, NOP0 at 1, RESP at 2, IDLE at 3
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("min_accept", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("min_nop0_we0", bus.command_we0, 1);
        chk("min_nop0_cmd", bus.command_in, 0);
        chk("min_nop0_busy", bus.busy, 1);
        @(negedge clk);
        chk("min_resp", bus.resp_valid, 1);
        chk("min_resp_we0", bus.command_we0, 0);
        @(negedge clk);
        chk("min_idle", bus.req_ready, 1);
        chk("min_resp_gone", bus.resp_valid, 0);

        run_job("basic", 0, 0, 0, 0, 100, 100, 4, 4, 0, 0, 0, 64'h11);
        run_job("exec37", 22, 0, 256, 512, 200, 200, 2, 2, 37, 0, 0, 0);
        run_job("timeout", 5, 1, 2, 3, 300, 300, 3, 3, 0, 0, 0, 0);
        run_job("coincide", 9, 7, 8, 9, 0, 0, 0, 1, TMO, 0, 0, 0);
        run_job("wrap", 0, 0, 0, 0, 1020, 1020, 8, 8, 0, 1, 0, 0);
        run_job("stall", 0, 0, 0, 0, 400, 400, 3, 3, 0, 0, 2, 0);
        run_job("clamp", 0, 0, 0, 0, 7, 7, 1500, 1100, 0, 0, 0, 0);

        // Reset during EXEC_WAIT aborts silently
        resp_n     = 0;
        done_delay = 0;
        @(posedge clk); #1;
        bus.req_ins    = 5'd3;
        bus.req_ld_len = 11'd0;
        bus.req_ul_len = 11'd0;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_init();
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_no_resp", 64'(resp_n), 0);
        run_job("after_rst", 4, 3, 2, 1, 50, 50, 2, 2, 10, 0, 0, 0);

        for (int k = 0; k < 20; k++) begin
            int lb_r;
            lb_r = $urandom_range(0, 1023);
            run_job($sformatf("rand%0d", k),
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
                    $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                    lb_r, ($urandom_range(0, 1) == 1) ? lb_r : $urandom_range(0, 1023),
                    $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 60),
                    $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
